// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the sequential ALU.
// Imported by alu_seq and its testbench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU.
// master: in_valid, a, b, ALUop out; in_ready, result, out_valid, busy in.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         ALUop;
    logic [2*WIDTH-1:0] result;
    logic               out_valid;
    logic               busy;

    modport master (
        output in_valid, a, b, ALUop,
        input  in_ready, result, out_valid, busy
    );

    modport slave (
        input  in_valid, a, b, ALUop,
        output in_ready, result, out_valid, busy
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Fixed-latency unsigned shift-add multiplier, WIDTH steps per product.
// Ports: clk, reset, start (load a/b), a, b, done (last step), product.
module seq_mult_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic               run;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    assign acc_nxt = acc + (mplr[0] ? mcand : '0);
    // done flags the final step so the caller can latch acc_nxt directly
    assign done    = run && (cnt == CW'(1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            run   <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= CW'(WIDTH);
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
        end else if (run) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CW'(1);
            if (done) run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus multi-cycle multiply.
// Ports: clk, reset, bus (alu_seq_if.slave: request, result, busy).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus
);
    state_t             state;
    state_t             state_nxt;
    logic               rdy_q;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] alu_res;
    logic [2*WIDTH-1:0] result_q;
    logic               out_valid_q;

    // rdy_q holds in_ready low for one cycle after reset releases
    assign bus.in_ready  = rdy_q && (state == S_IDLE);
    assign bus.busy      = (state == S_MUL);
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (bus.ALUop == OP_MUL);
    assign sum       = {1'b0, bus.a} + {1'b0, bus.b};

    always_comb begin
        alu_res = '0;
        unique case (bus.ALUop)
            OP_ADD: alu_res[WIDTH:0]   = sum;
            OP_SUB: alu_res[WIDTH-1:0] = bus.a - bus.b;
            OP_SLT: alu_res[0]         = $signed(bus.a) < $signed(bus.b);
            OP_AND: alu_res[WIDTH-1:0] = bus.a & bus.b;
            OP_OR:  alu_res[WIDTH-1:0] = bus.a | bus.b;
            OP_XOR: alu_res[WIDTH-1:0] = bus.a ^ bus.b;
            OP_NOR: alu_res[WIDTH-1:0] = ~(bus.a | bus.b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (mul_start) state_nxt = S_MUL;
            S_MUL:  if (mul_done)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rdy_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdy_q       <= 1'b1;
            out_valid_q <= 1'b0;
            if (accept && !mul_start) begin
                result_q    <= alu_res;
                out_valid_q <= 1'b1;
            end else if (mul_done) begin
                result_q    <= mul_prod;
                out_valid_q <= 1'b1;
            end
        end
    end

    seq_mult_unit #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );
endmodule
